// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared types and opcode helpers for the ALU scheduler
package alu_sched_pkg;

    typedef enum logic [3:0] {
        OP_ARITH0 = 4'd0,
        OP_ARITH1 = 4'd1,
        OP_ARITH2 = 4'd2,
        OP_ARITH3 = 4'd3,
        OP_AND    = 4'd4,
        OP_OR     = 4'd5,
        OP_XOR    = 4'd6,
        OP_SHL    = 4'd7,
        OP_SHR    = 4'd8
    } alu_op_e;

    // Highest opcode the ALU understands; anything above is rejected.
    localparam logic [3:0] SEL_MAX = OP_SHR;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    function automatic logic sel_is_legal(input logic [3:0] sel);
        return sel <= SEL_MAX;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant search starting at ptr
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    input  logic                    en,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx
);

    localparam int IW = $clog2(NREQ);

    logic found;

    // Two passes with constant indices: first requesters at or above ptr, then the wrapped ones below it.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (en && !found && req[j] && (IW'(j) >= ptr)) begin
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
                found   = 1'b1;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (en && !found && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// rtl/alu_scheduler.sv - round-robin sharing of one vectorial ALU among NREQ requesters
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int N       = 1,
    parameter int NREQ    = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH*N-1:0]   req_a,
    input  logic [NREQ*WIDTH*N-1:0]   req_b,
    input  logic [NREQ*4-1:0]         req_sel,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [WIDTH*N-1:0]        rsp_z,
    output logic [8*N-1:0]            rsp_os,
    output logic                      rsp_err,
    output logic [WIDTH*N-1:0]        alu_a,
    output logic [WIDTH*N-1:0]        alu_b,
    output logic [3:0]                alu_sel,
    output logic [N-1:0]              alu_enable,
    input  logic [WIDTH*N-1:0]        alu_z,
    input  logic [8*N-1:0]            alu_os,
    output logic                      busy
);

    localparam int DW = WIDTH * N;
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(ALU_LAT + 1);

    sched_state_e state, state_next;

    logic [IW-1:0]   rr_ptr;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   lat_a, lat_b;
    logic [3:0]      lat_sel;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            hs;
    logic            arb_en;

    logic [DW-1:0] a_arr [NREQ];
    logic [DW-1:0] b_arr [NREQ];
    logic [3:0]    s_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*DW +: DW];
        assign b_arr[i] = req_b[i*DW +: DW];
        assign s_arr[i] = req_sel[i*4 +: 4];
    end

    // Grants only in IDLE, and never while reset is held so req_ready reads 0 during reset.
    assign arb_en = (state == IDLE) && arst;
    assign hs     = |gnt;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and all state-decoded outputs; ALU operands are only driven while the op is in flight.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        alu_enable = '0;
        alu_a      = '0;
        alu_b      = '0;
        alu_sel    = '0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = gnt;
                if (hs) begin
                    state_next = sel_is_legal(s_arr[gnt_idx]) ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                alu_enable = '1;
                alu_a      = lat_a;
                alu_b      = lat_b;
                alu_sel    = lat_sel;
                state_next = WAIT;
            end
            WAIT: begin
                alu_a   = lat_a;
                alu_b   = lat_b;
                alu_sel = lat_sel;
                if (cnt == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the granted request, advance the pointer, count ALU latency and capture the response.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            rr_ptr  <= '0;
            cnt     <= '0;
            lat_a   <= '0;
            lat_b   <= '0;
            lat_sel <= '0;
            rsp_id  <= '0;
            rsp_z   <= '0;
            rsp_os  <= '0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        lat_a   <= a_arr[gnt_idx];
                        lat_b   <= b_arr[gnt_idx];
                        lat_sel <= s_arr[gnt_idx];
                        rsp_id  <= gnt_idx;
                        rr_ptr  <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                        if (!sel_is_legal(s_arr[gnt_idx])) begin
                            rsp_err <= 1'b1;
                            rsp_z   <= '0;
                            rsp_os  <= '0;
                        end
                    end
                end
                ISSUE: begin
                    cnt <= CW'(ALU_LAT - 1);
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_z   <= alu_z;
                        rsp_os  <= alu_os;
                        rsp_err <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// tb/tb_alu_scheduler.sv - directed self-checking bench for alu_scheduler
module tb_alu_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // DUT with ALU_LAT=1
    logic        arst;
    logic [3:0]  req_valid, req_ready;
    logic [15:0] req_a, req_b, req_sel;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_z, alu_a, alu_b, alu_sel, alu_z;
    logic [7:0]  rsp_os, alu_os;
    logic [0:0]  alu_enable;

    // DUT with ALU_LAT=3
    logic        arst3;
    logic [3:0]  v3, rdy3;
    logic [15:0] a3, b3, s3;
    logic        rv3, rr3, err3, busy3;
    logic [1:0]  id3;
    logic [3:0]  z3, aa3, ab3, as3, az3;
    logic [7:0]  os3, aos3;
    logic [0:0]  ae3;

    alu_scheduler #(.WIDTH(4), .N(1), .NREQ(4), .ALU_LAT(1)) dut (
        .clk(clk), .arst(arst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
        .rsp_os(rsp_os), .rsp_err(rsp_err), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_enable(alu_enable), .alu_z(alu_z), .alu_os(alu_os), .busy(busy)
    );

    alu_scheduler #(.WIDTH(4), .N(1), .NREQ(4), .ALU_LAT(3)) dut3 (
        .clk(clk), .arst(arst3), .req_valid(v3), .req_ready(rdy3),
        .req_a(a3), .req_b(b3), .req_sel(s3),
        .rsp_valid(rv3), .rsp_ready(rr3), .rsp_id(id3), .rsp_z(z3),
        .rsp_os(os3), .rsp_err(err3), .alu_a(aa3), .alu_b(ab3), .alu_sel(as3),
        .alu_enable(ae3), .alu_z(az3), .alu_os(aos3), .busy(busy3)
    );

    function automatic logic [11:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
        logic [4:0]  s;
        logic [11:0] r;
        s = 5'b0;
        r = 12'h0;
        case (sel)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = {7'b0, s[4], s[3:0]}; end
            4'd1: begin s = {1'b0, a} - {1'b0, b}; r = {7'b0, s[4], s[3:0]}; end
            4'd4: r = {8'h00, a & b};
            4'd5: r = {8'h00, a | b};
            4'd6: r = {8'h00, a ^ b};
            4'd7: r = {8'h00, a << b};
            4'd8: r = {8'h00, a >> b};
            default: r = 12'h0;
        endcase
        return r;
    endfunction

    // ALU stand-ins: result appears ALU_LAT clocks after the enable cycle, for one cycle only
    logic [11:0] q1 = '0;
    logic [11:0] p3_0 = '0, p3_1 = '0, p3_2 = '0;
    always @(posedge clk) begin
        q1   <= alu_enable[0] ? alu_f(alu_a, alu_b, alu_sel) : 12'h0;
        p3_0 <= ae3[0] ? alu_f(aa3, ab3, as3) : 12'h0;
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign alu_z  = q1[3:0];
    assign alu_os = q1[11:4];
    assign az3    = p3_2[3:0];
    assign aos3   = p3_2[11:4];

    task automatic do_reset();
        @(negedge clk); arst = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        @(negedge clk); arst = 1'b1;
    endtask

    task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel,
                          output logic [3:0] z, output logic [7:0] os, output logic err,
                          output logic [1:0] rid, output bit to);
        int n;
        @(negedge clk);
        req_a[id*4 +: 4] = a; req_b[id*4 +: 4] = b; req_sel[id*4 +: 4] = sel;
        req_valid = '0; req_valid[id] = 1'b1; rsp_ready = 1'b0;
        #1; n = 0;
        while (req_ready[id] !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk); req_valid = '0;
        while (rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        z = rsp_z; os = rsp_os; err = rsp_err; rid = rsp_id; to = (n >= 40);
        rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 4'b0101;
        @(negedge clk); @(negedge clk);
        tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if ({alu_enable, alu_a, alu_b, alu_sel} !== 13'h0) begin tests_failed++; $display("FAIL reset_alu: got %h want 0", {alu_enable, alu_a, alu_b, alu_sel}); end
        tests_run++; if ({rsp_id, rsp_z, rsp_os, rsp_err} !== 15'h0) begin tests_failed++; $display("FAIL reset_rsp: got %h want 0", {rsp_id, rsp_z, rsp_os, rsp_err}); end
        req_valid = '0; arst = 1'b1;
    endtask

    task automatic test_single_and();
        @(negedge clk);
        req_a[3:0] = 4'b1010; req_b[3:0] = 4'b0101; req_sel[3:0] = 4'd4;
        req_valid = 4'b0001; rsp_ready = 1'b0;
        #1;
        tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL and_grant: got %b want 0001", req_ready); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 4'b0000;
            tests_run++; if (alu_enable[0] !== (c == 1)) begin tests_failed++; $display("FAIL and_enable_c%0d: got %b want %b", c, alu_enable, (c == 1)); end
            tests_run++; if (rsp_valid !== (c == 3)) begin tests_failed++; $display("FAIL and_rsp_valid_c%0d: got %b want %b", c, rsp_valid, (c == 3)); end
            if (c == 1) begin
                tests_run++; if ({alu_a, alu_b, alu_sel} !== 12'hA54) begin tests_failed++; $display("FAIL and_alu_operands: got %h want a54", {alu_a, alu_b, alu_sel}); end
            end
            if (c == 3) begin
                tests_run++; if ({rsp_id, rsp_z, rsp_err} !== 7'b00_0000_0) begin tests_failed++; $display("FAIL and_rsp: got id=%0d z=%b err=%b want id=0 z=0000 err=0", rsp_id, rsp_z, rsp_err); end
                rsp_ready = 1'b1;
            end
            if (c == 4) begin
                rsp_ready = 1'b0;
                tests_run++; if ({busy, alu_a} !== 5'b0) begin tests_failed++; $display("FAIL and_idle_after: got busy=%b alu_a=%b want 0", busy, alu_a); end
            end
        end
    endtask

    task automatic test_round_robin();
        int gnt_ids[5];
        int gnt_cyc[5];
        int rsp_ids[5];
        logic [3:0] rsp_zs[5];
        int ng, nr, cyc;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i*4 +: 4] = 4'(i + 1); req_b[i*4 +: 4] = 4'b1000; req_sel[i*4 +: 4] = 4'd5;
        end
        rsp_ready = 1'b1; req_valid = 4'b1111;
        ng = 0; nr = 0; cyc = 0;
        #1;
        while (nr < 5 && cyc < 60) begin
            if (ng < 5 && req_ready != 4'b0000) begin
                for (int j = 0; j < 4; j++) if (req_ready[j]) gnt_ids[ng] = j;
                gnt_cyc[ng] = cyc; ng++;
            end
            if (rsp_valid === 1'b1) begin rsp_ids[nr] = int'(rsp_id); rsp_zs[nr] = rsp_z; nr++; end
            @(negedge clk); cyc++;
            if (ng >= 5) req_valid = 4'b0000;
            #1;
        end
        tests_run++; if (nr != 5) begin tests_failed++; $display("FAIL rr_timeout: got %0d responses want 5", nr); end
        for (int i = 0; i < ng; i++) begin
            tests_run++; if (gnt_ids[i] != i % 4) begin tests_failed++; $display("FAIL rr_grant_%0d: got %0d want %0d", i, gnt_ids[i], i % 4); end
            if (i > 0) begin
                tests_run++; if (gnt_cyc[i] - gnt_cyc[i-1] != 4) begin tests_failed++; $display("FAIL rr_spacing_%0d: got %0d want 4", i, gnt_cyc[i] - gnt_cyc[i-1]); end
            end
        end
        for (int i = 0; i < nr; i++) begin
            tests_run++; if (rsp_ids[i] != i % 4) begin tests_failed++; $display("FAIL rr_rsp_id_%0d: got %0d want %0d", i, rsp_ids[i], i % 4); end
            tests_run++; if (rsp_zs[i] !== (4'((i % 4) + 1) | 4'b1000)) begin tests_failed++; $display("FAIL rr_rsp_z_%0d: got %b want %b", i, rsp_zs[i], 4'((i % 4) + 1) | 4'b1000); end
        end
        req_valid = '0; rsp_ready = 1'b0;
    endtask

    task automatic test_arith();
        logic [3:0] z; logic [7:0] os; logic err; logic [1:0] rid; bit to;
        run_op(0, 4'b1111, 4'b0001, 4'd0, z, os, err, rid, to);
        tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL add_timeout: got %b want 0", to); end
        tests_run++; if ({rid, z, os, err} !== {2'd0, 4'b0000, 8'h01, 1'b0}) begin tests_failed++; $display("FAIL add_rsp: got id=%0d z=%b os=%h err=%b want id=0 z=0000 os=01 err=0", rid, z, os, err); end
        run_op(2, 4'b0010, 4'b0011, 4'd1, z, os, err, rid, to);
        tests_run++; if ({rid, z, os, err} !== {2'd2, 4'b1111, 8'h01, 1'b0}) begin tests_failed++; $display("FAIL sub_rsp: got id=%0d z=%b os=%h err=%b want id=2 z=1111 os=01 err=0", rid, z, os, err); end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        req_a[11:8] = 4'b0110; req_b[11:8] = 4'b0011; req_sel[11:8] = 4'b1111;
        req_valid = 4'b0100; rsp_ready = 1'b0;
        #1;
        tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL ill_grant: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        tests_run++; if (alu_enable !== 1'b0) begin tests_failed++; $display("FAIL ill_enable: got %b want 0", alu_enable); end
        tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL ill_rsp_valid: got %b want 1", rsp_valid); end
        tests_run++; if ({rsp_id, rsp_z, rsp_os, rsp_err} !== {2'd2, 4'h0, 8'h00, 1'b1}) begin tests_failed++; $display("FAIL ill_rsp: got id=%0d z=%b os=%h err=%b want id=2 z=0 os=0 err=1", rsp_id, rsp_z, rsp_os, rsp_err); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        tests_run++; if ({rsp_valid, busy, alu_enable} !== 3'b000) begin tests_failed++; $display("FAIL ill_after: got %b want 000", {rsp_valid, busy, alu_enable}); end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        req_a[3:0] = 4'b1111; req_b[3:0] = 4'b0000; req_sel[3:0] = 4'd6;
        req_a[7:4] = 4'b0011; req_b[7:4] = 4'b0100; req_sel[7:4] = 4'd5;
        req_valid = 4'b0011; rsp_ready = 1'b0;
        #1;
        tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL bp_grant0: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0010;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        tests_run++; if (n >= 20) begin tests_failed++; $display("FAIL bp_timeout: got no rsp_valid want rsp_valid within 20 cycles"); end
        for (int k = 0; k < 5; k++) begin
            tests_run++; if ({rsp_valid, rsp_id, rsp_z} !== {1'b1, 2'd0, 4'b1111}) begin tests_failed++; $display("FAIL bp_hold_%0d: got v=%b id=%0d z=%b want v=1 id=0 z=1111", k, rsp_valid, rsp_id, rsp_z); end
            tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL bp_ready_%0d: got %b want 0000", k, req_ready); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL bp_ready_same_cycle: got %b want 0000", req_ready); end
        @(negedge clk);
        rsp_ready = 1'b0;
        tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL bp_grant1: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        tests_run++; if ({rsp_valid, rsp_id, rsp_z} !== {1'b1, 2'd1, 4'b0111}) begin tests_failed++; $display("FAIL bp_rsp1: got v=%b id=%0d z=%b want v=1 id=1 z=0111", rsp_valid, rsp_id, rsp_z); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_shifts();
        logic [3:0] z; logic [7:0] os; logic err; logic [1:0] rid; bit to;
        run_op(3, 4'b1111, 4'b0001, 4'd7, z, os, err, rid, to);
        tests_run++; if ({to, rid, z, err} !== {1'b0, 2'd3, 4'b1110, 1'b0}) begin tests_failed++; $display("FAIL shl_rsp: got to=%b id=%0d z=%b err=%b want to=0 id=3 z=1110 err=0", to, rid, z, err); end
        run_op(1, 4'b1111, 4'b0001, 4'd8, z, os, err, rid, to);
        tests_run++; if ({to, rid, z, err} !== {1'b0, 2'd1, 4'b0111, 1'b0}) begin tests_failed++; $display("FAIL shr_rsp: got to=%b id=%0d z=%b err=%b want to=0 id=1 z=0111 err=0", to, rid, z, err); end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        arst3 = 1'b1;
        @(negedge clk);
        a3[7:4] = 4'b1100; b3[7:4] = 4'b1010; s3[7:4] = 4'd6; v3 = 4'b0010; rr3 = 1'b0;
        #1;
        tests_run++; if (rdy3 !== 4'b0010) begin tests_failed++; $display("FAIL riw_grant: got %b want 0010", rdy3); end
        @(negedge clk);
        v3 = '0;
        tests_run++; if (ae3 !== 1'b1) begin tests_failed++; $display("FAIL riw_issue: got %b want 1", ae3); end
        @(negedge clk);
        tests_run++; if ({busy3, ae3, aa3, as3} !== {1'b1, 1'b0, 4'b1100, 4'd6}) begin tests_failed++; $display("FAIL riw_wait: got busy=%b en=%b a=%b sel=%0d want busy=1 en=0 a=1100 sel=6", busy3, ae3, aa3, as3); end
        @(negedge clk);
        v3 = 4'b1010; arst3 = 1'b0;
        #1;
        tests_run++; if ({rdy3, rv3, busy3, ae3} !== 7'b0) begin tests_failed++; $display("FAIL riw_reset_ctrl: got %b want 0", {rdy3, rv3, busy3, ae3}); end
        tests_run++; if ({aa3, ab3, as3} !== 12'h0) begin tests_failed++; $display("FAIL riw_reset_alu: got %h want 0", {aa3, ab3, as3}); end
        tests_run++; if ({id3, z3, os3, err3} !== 15'h0) begin tests_failed++; $display("FAIL riw_reset_rsp: got %h want 0", {id3, z3, os3, err3}); end
        @(negedge clk);
        v3 = '0; arst3 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tests_run++; if ({rv3, busy3} !== 2'b00) begin tests_failed++; $display("FAIL riw_no_rsp_%0d: got %b want 00", k, {rv3, busy3}); end
        end
        @(negedge clk);
        a3[7:4] = 4'b1100; b3[7:4] = 4'b1010; s3[7:4] = 4'd4;
        a3[15:12] = 4'b1111; b3[15:12] = 4'b0000; s3[15:12] = 4'd6;
        v3 = 4'b1010;
        #1;
        tests_run++; if (rdy3 !== 4'b0010) begin tests_failed++; $display("FAIL riw_ptr_restart: got %b want 0010", rdy3); end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) v3 = '0;
            tests_run++; if (ae3[0] !== (c == 1)) begin tests_failed++; $display("FAIL riw_enable_c%0d: got %b want %b", c, ae3, (c == 1)); end
            tests_run++; if (rv3 !== (c == 5)) begin tests_failed++; $display("FAIL riw_rsp_valid_c%0d: got %b want %b", c, rv3, (c == 5)); end
        end
        tests_run++; if ({id3, z3, err3} !== {2'd1, 4'b1000, 1'b0}) begin tests_failed++; $display("FAIL riw_rsp: got id=%0d z=%b err=%b want id=1 z=1000 err=0", id3, z3, err3); end
        rr3 = 1'b1;
        @(negedge clk);
        rr3 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        arst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;
        arst3 = 1'b0; v3 = '0; a3 = '0; b3 = '0; s3 = '0; rr3 = 1'b0;
        test_reset();
        test_single_and();
        test_round_robin();
        test_arith();
        test_illegal();
        test_backpressure();
        test_shifts();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Round-robin scheduler sharing one `Vectorial_ALU` instance among `NREQ` requesters. It accepts one operation at a time over a valid/ready handshake and rejects illegal opcodes without touching the ALU. Legal operations are driven to the ALU and held for the ALU latency, then the result and flags are returned tagged with the requester index. It sits between the requesting datapath blocks and the ALU, and is the only driver of the ALU's `A`, `B`, `sel` and `enable` inputs.

## Interface
- `WIDTH`, 4: bits per ALU lane.
- `N`, 1: number of ALU lanes; operand width is `WIDTH*N`.
- `NREQ`, 4: number of requesters, 2..16.
- `ALU_LAT`, 1: ALU result latency in clocks after the enable cycle, 1..8.
- `clk` in 1: single clock, rising edge.
- `arst` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: per-requester operation valid.
- `req_ready` out NREQ: one-hot grant/accept.
- `req_a`, `req_b` in NREQ×(WIDTH*N): operands, packed per requester.
- `req_sel` in NREQ×4: opcode per requester.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumed.
- `rsp_id` out $clog2(NREQ): index of the requester that owns the response.
- `rsp_z` out WIDTH*N: ALU result.
- `rsp_os` out 8*N: ALU overflow/borrow flags.
- `rsp_err` out 1: illegal opcode.
- `alu_a`, `alu_b` out WIDTH*N: drive the ALU `A` and `B` inputs.
- `alu_sel` out 4: drives the ALU `sel` input.
- `alu_enable` out N: drives the ALU `enable` input.
- `alu_z` in WIDTH*N: from the ALU `Z` output.
- `alu_os` in 8*N: from the ALU `os` output.
- `busy` out 1: state is not IDLE.

## Operation
- Legal opcodes are 0..8:
  - 0..3: arithmetic.
  - 4: AND. 5: OR. 6: XOR.
  - 7: shift left. 8: shift right.
  - 9..15 are illegal.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - The grant goes to the first requester with `req_valid` set, searching from `rr_ptr` upward with wrap-around.
  - `req_ready[g]` is asserted combinationally in IDLE only.
  - On the handshake edge: latch `req_a[g]`, `req_b[g]`, `req_sel[g]` and `g`, and set `rr_ptr <= (g+1) mod NREQ`.
  - Next state is ISSUE if the opcode is legal.
  - Otherwise next state is RESP with `rsp_err`=1, `rsp_z`=0, `rsp_os`=0.
- **ISSUE**
  - `alu_enable` is all ones for exactly one cycle.
  - `alu_a`, `alu_b` and `alu_sel` carry the latched values from ISSUE through the end of WAIT.
  - Load the WAIT counter with `ALU_LAT-1`.
- **WAIT**
  - `alu_enable` is 0.
  - When the counter reaches 0: capture `alu_z`/`alu_os` into `rsp_z`/`rsp_os`, set `rsp_err`=0, go to RESP.
  - Otherwise decrement the counter.
- **RESP**
  - `rsp_valid`=1; all `rsp_*` fields are held stable until `rsp_ready`.
  - All `req_ready` are 0.
  - On `rsp_ready`, go to IDLE. No grant happens in the same cycle.
- `alu_a`, `alu_b` and `alu_sel` return to 0 in IDLE.
- A requester's `req_valid` is ignored while another transaction is in flight. Requesters hold their request until granted.

## Timing
- Take the handshake cycle as cycle 0. Legal op:
  - Cycle 1: ISSUE.
  - Cycles 2..ALU_LAT+1: WAIT.
  - Cycle ALU_LAT+2: `rsp_valid` rises.
- Illegal op: `rsp_valid` rises in cycle 1.
- Peak throughput is one operation per ALU_LAT+3 cycles when `rsp_ready` is tied high.
- Reset values (asynchronous, while `arst`=0):
  - State IDLE, `rr_ptr`=0, counter 0.
  - `req_ready`, `rsp_valid`, `rsp_id`, `rsp_z`, `rsp_os` are 0.
  - `rsp_err`, `alu_a`, `alu_b`, `alu_sel`, `alu_enable`, `busy` are 0.
- Reset mid-transaction (any non-IDLE state): the accepted transaction is dropped with no response. The first grant after reset release starts from requester 0.
- Simultaneous requests: at most one grant per IDLE cycle. Round-robin bounds the wait to NREQ-1 transactions.
- `rsp_ready` asserted outside RESP is ignored.

## Structure
- Package `alu_sched_pkg` holds:
  - `alu_op_e`, opcodes 0..8.
  - `SEL_MAX`=8.
  - `sched_state_e` (IDLE/ISSUE/WAIT/RESP).
- Sub-module `rr_arbiter` (parameter NREQ) takes `req`, `ptr` and `en`, and produces a one-hot `gnt` and an encoded `gnt_idx`. It is purely combinational. The pointer register stays in the scheduler.

## Test plan
- **Single AND:** reset, then requester 0 sends `sel`=4, A=4'b1010, B=4'b0101, with ALU_LAT=1. Required: `rsp_valid` in cycle 3, `rsp_id`=0, `rsp_z`=4'b0000, `rsp_err`=0, `alu_enable` high only in cycle 1.
- **Round-robin order:** all 4 requesters hold valid continuously with `sel`=5, `rsp_ready`=1. Required: grants in order 0,1,2,3,0, and `rsp_id` follows the same order.
- **Illegal opcode:** requester 2 sends `sel`=4'b1111. Required: `alu_enable` never asserted, `rsp_valid` in cycle 1, `rsp_err`=1, `rsp_z`=0, `rsp_id`=2.
- **Backpressure:** an XOR with A=4'b1111, B=4'b0000 completes while `rsp_ready` is held low for 5 cycles and requester 1 is valid. Required: `rsp_z`=4'b1111 stable throughout, `req_ready`=0 throughout, requester 1 granted the cycle after `rsp_ready`.
- **Shifts:** A=4'b1111, B=4'b0001. Required: `sel`=7 returns 4'b1110, `sel`=8 returns 4'b0111.
- **Reset in WAIT:** assert `arst`=0 during WAIT with ALU_LAT=3. Required: all outputs 0 immediately, no response after release, next grant searches from requester 0.
